// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the async-FIFO read-side drain engine.
//   DEFAULT_DATA_WIDTH : default word width shared by the FIFO and the drain.
//   rd_state_e         : drain FSM states (IDLE / RUN / STOP).
//   stream_beat_t      : one output beat {data, last} at the default width.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic                          last;
  } stream_beat_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the FIFO read port and the outgoing valid/ready stream.
//   fifo_empty / fifo_rd_data : show-ahead FIFO read side (into the drain)
//   fifo_rd_en                : FIFO pop strobe (from the drain)
//   m_valid / m_data / m_last : output stream (from the drain)
//   m_ready                   : downstream accept (into the drain)
// Modports: master = the drain engine, slave = FIFO + downstream side.
// ---------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry valid/ready register slice. The head entry drives the registered
// outputs; the spare entry absorbs one word when the head stalls, so the
// upstream may push in the same cycle the head is blocked.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_data/in_last, in_ready : upstream side (in_ready combinational
//                                        from out_ready only)
//   out_valid/out_data/out_last, out_ready : downstream side (registered)
//   occupied            : at least one entry holds a word
// ---------------------------------------------------------------------------
module fifo_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             occupied
);

  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic             head_last_q, head_last_d;
  logic             spare_valid_q, spare_valid_d;
  logic [WIDTH-1:0] spare_data_q, spare_data_d;
  logic             spare_last_q, spare_last_d;
  logic             head_hs_s;

  assign head_hs_s = head_valid_q && out_ready;
  // Room exists unless both entries are full and the head is not retiring.
  assign in_ready  = !spare_valid_q || out_ready;

  // Next-state of the two entries: the head refills from spare first so order is kept
  always_comb begin
    head_valid_d  = head_valid_q;
    head_data_d   = head_data_q;
    head_last_d   = head_last_q;
    spare_valid_d = spare_valid_q;
    spare_data_d  = spare_data_q;
    spare_last_d  = spare_last_q;
    if (!head_valid_q || head_hs_s) begin
      if (spare_valid_q) begin
        head_valid_d  = 1'b1;
        head_data_d   = spare_data_q;
        head_last_d   = spare_last_q;
        spare_valid_d = in_valid;
        spare_data_d  = in_data;
        spare_last_d  = in_last;
      end else begin
        head_valid_d  = in_valid;
        spare_valid_d = 1'b0;
        if (in_valid) begin
          head_data_d = in_data;
          head_last_d = in_last;
        end else begin
          head_data_d = head_data_q;
          head_last_d = head_last_q;
        end
      end
    end else begin
      // Head stalled: it holds, a new word can only go to the spare slot.
      if (in_valid) begin
        spare_valid_d = 1'b1;
        spare_data_d  = in_data;
        spare_last_d  = in_last;
      end else begin
        spare_valid_d = spare_valid_q;
      end
    end
  end

  // Entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q  <= 1'b0;
      head_data_q   <= {WIDTH{1'b0}};
      head_last_q   <= 1'b0;
      spare_valid_q <= 1'b0;
      spare_data_q  <= {WIDTH{1'b0}};
      spare_last_q  <= 1'b0;
    end else begin
      head_valid_q  <= head_valid_d;
      head_data_q   <= head_data_d;
      head_last_q   <= head_last_d;
      spare_valid_q <= spare_valid_d;
      spare_data_q  <= spare_data_d;
      spare_last_q  <= spare_last_d;
    end
  end

  assign out_valid = head_valid_q;
  assign out_data  = head_data_q;
  assign out_last  = head_last_q;
  assign occupied  = head_valid_q || spare_valid_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for the async FIFO (rd_clk domain). Pops words while
// the skid buffer has room and re-emits them as fixed-length packets on a
// valid/ready stream with m_last on every PKT_LEN-th word.
//   rd_clk, rd_rst : read clock, asynchronous active-high reset
//   en             : level-sensitive drain enable; packets are never cut short
//   bus (master)   : FIFO read port + output stream (see fifo_rd_stream_if)
//   busy           : FSM not IDLE or skid buffer holds a word
//   pkt_count      : packets delivered (saturating)
//   stall_count    : cycles with m_valid && !m_ready (saturating)
// Optional feature macro: FIFO_RD_STREAM_STATS_EN enables the two counters;
// without it both ports read constant zero.
// The FIFO's rd_rst_n must be driven from ~rd_rst so its read pointer
// realigns with the words discarded here on reset.
// ---------------------------------------------------------------------------
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 en,
  fifo_rd_stream_if.master     bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PKT_LEN - 1);

  rd_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  pop_idx_q, pop_idx_d;
  logic                  pop_s;
  logic                  last_s;
  logic                  in_ready_s;
  logic                  out_valid_s;
  logic [DATA_WIDTH-1:0] out_data_s;
  logic                  out_last_s;
  logic                  occupied_s;

  assign last_s = (pop_idx_q == LAST_IDX);
  // m_ready reaches fifo_rd_en through in_ready; no other combinational path.
  assign pop_s  = (state_q != IDLE) && !bus.fifo_empty && in_ready_s;
  assign bus.fifo_rd_en = pop_s;

  // Packet position and drain FSM next-state
  always_comb begin
    state_d   = state_q;
    pop_idx_d = pop_idx_q;
    if (pop_s) begin
      if (last_s) begin
        pop_idx_d = {CNT_WIDTH{1'b0}};
      end else begin
        pop_idx_d = pop_idx_q + CNT_WIDTH'(1);
      end
    end else begin
      pop_idx_d = pop_idx_q;
    end
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
        else    state_d = IDLE;
      end
      RUN: begin
        // Judge on the post-pop index: a pop in the cycle en falls opens a
        // packet that must then be finished in STOP.
        if (en)                                  state_d = RUN;
        else if (pop_idx_d != {CNT_WIDTH{1'b0}}) state_d = STOP;
        else                                     state_d = IDLE;
      end
      STOP: begin
        if (en)                   state_d = RUN;
        else if (pop_s && last_s) state_d = IDLE;
        else                      state_d = STOP;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and packet-position registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q   <= IDLE;
      pop_idx_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      pop_idx_q <= pop_idx_d;
    end
  end

  fifo_skid_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .in_valid  (pop_s),
    .in_data   (bus.fifo_rd_data),
    .in_last   (last_s),
    .in_ready  (in_ready_s),
    .out_valid (out_valid_s),
    .out_data  (out_data_s),
    .out_last  (out_last_s),
    .out_ready (bus.m_ready),
    .occupied  (occupied_s)
  );

  assign bus.m_valid = out_valid_s;
  assign bus.m_data  = out_data_s;
  assign bus.m_last  = out_last_s;
  assign busy        = (state_q != IDLE) || occupied_s;

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) return v;
    else                        return v + CNT_WIDTH'(1);
  endfunction

  // Statistics next-state: completed packets and backpressured cycles
  always_comb begin
    pkt_count_d   = pkt_count_q;
    stall_count_d = stall_count_q;
    if (out_valid_s && bus.m_ready && out_last_s) pkt_count_d = sat_inc(pkt_count_q);
    else                                          pkt_count_d = pkt_count_q;
    if (out_valid_s && !bus.m_ready) stall_count_d = sat_inc(stall_count_q);
    else                             stall_count_d = stall_count_q;
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pkt_count_q   <= {CNT_WIDTH{1'b0}};
      stall_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`else
  assign pkt_count   = {CNT_WIDTH{1'b0}};
  assign stall_count = {CNT_WIDTH{1'b0}};
`endif

endmodule
